riscv_rf_wr_arbiter: RTL and testbench
======================================

// Module: riscv_rf_wr_arbiter
// PURPOSE
//  Shares the single register-file write port among NREQ writeback requesters (ALU, load, CSR, mul/div).
//  Uses a round-robin valid/ready handshake and a one-entry registered output stage.
//  The output stage drives the register-file write enable, address and data.
//  Sits between the writeback sources and the register-file / pipeline-register write enables.
// PARAMETERS
//  XLEN  32  data width of a write
//  NREQ  4   number of requesters; legal range 2..8
//  AW    5   register address width
// PORTS
//  i_rfarb_clk        in   1          single clock; all state updates on rising edge
//  i_rfarb_rst        in   1          asynchronous, active-high reset
//  i_rfarb_req_valid  in   NREQ       per-requester write request
//  o_rfarb_req_ready  out  NREQ       per-requester accept; one-hot or zero
//  i_rfarb_req_addr   in   NREQ*AW    packed rd addresses; requester k at [k*AW +: AW]
//  i_rfarb_req_data   in   NREQ*XLEN  packed write data; requester k at [k*XLEN +: XLEN]
//  i_rfarb_wr_stall   in   1          downstream cannot take a write this cycle
//  o_rfarb_wr_en      out  1          register-file write enable
//  o_rfarb_wr_addr    out  AW         write address
//  o_rfarb_wr_data    out  XLEN       write data
//  o_rfarb_grant_id   out  clog2(NREQ) index of the requester owning the current write
//  o_rfarb_busy       out  1          any request pending or output stage occupied
// BEHAVIOUR
//  Reset
//  - While i_rfarb_rst is high: o_rfarb_wr_en=0, wr_addr=0, wr_data=0, grant_id=0, ready=0, priority pointer=0.
//  - Asserting reset mid-write discards the held entry immediately; nothing is replayed after reset.
//  Output stage
//  - One entry, with states EMPTY (wr_en=0) and FULL (wr_en=1).
//  - The stage can load when EMPTY, or when FULL and i_rfarb_wr_stall=0 (simultaneous drain and refill).
//  Arbitration (combinational, per cycle)
//  - Active only while the stage can load.
//  - Search starts at the pointer and wraps NREQ-1 -> 0; the first requester with valid=1 wins.
//  - Only the winner sees ready=1. All ready bits are 0 when the stage cannot load.
//  Handshake
//  - A request is transferred on a cycle where valid & ready = 1.
//  - The requester must hold valid, addr and data stable until ready.
//  - ready may depend combinationally on valid, stall and the pointer.
//  Transfer
//  - On the next edge the stage loads {addr, data, id} and becomes FULL.
//  - The pointer becomes (winner+1) mod NREQ.
//  - Latency is exactly 1 cycle from the accept cycle to o_rfarb_wr_en=1.
//  Draining
//  - If FULL, stall=0 and no transfer occurs, the stage goes EMPTY on the next edge.
//  - If FULL and stall=1, the stage stays FULL and wr_addr, wr_data and grant_id hold unchanged.
//  Pointer
//  - The pointer never moves without a transfer, so a requester waiting behind a stall keeps its priority.
//  Fairness
//  - With all NREQ requesters continuously valid and stall=0, each is granted exactly once per NREQ cycles.
//  Idle
//  - With no valid request, the pointer and held data are unchanged.
//  - wr_addr and wr_data keep their last values while wr_en=0.
//  o_rfarb_busy
//  - Equals (|i_rfarb_req_valid) | wr_en. Purely combinational.
// CONFIGURATION
//  RISCV_RF_ARB_X0_FILTER_EN
//  - Defined:
//    - A winning request with addr==0 is still accepted (ready=1) and still advances the pointer.
//    - It does not load the stage: the stage goes or stays EMPTY exactly as if no transfer occurred.
//    - The x0 write therefore consumes an arbitration slot but produces no wr_en pulse.
//  - Undefined:
//    - addr==0 requests are forwarded like any other request.
//    - The register file is responsible for ignoring x0.
// TESTING
//  1. Reset, then req0 valid, addr=5, data=0xDEADBEEF, stall=0.
//     -> ready[0]=1 in cycle 0.
//     -> wr_en=1, wr_addr=5, wr_data=0xDEADBEEF, grant_id=0 in cycle 1.
//     -> wr_en=0 in cycle 2.
//  2. All 4 requesters valid continuously, stall=0.
//     -> grant_id sequence 0,1,2,3,0,1, one per cycle.
//     -> wr_en held 1 with no gaps.
//  3. Stage FULL with id=1, addr=7; stall=1 for 3 cycles while req2 is valid.
//     -> wr_addr=7 and grant_id=1 held for 3 cycles, ready=0.
//     -> On stall release, ready[2]=1 that cycle and grant_id=2 next cycle (drain and refill, no bubble).
//  4. Assert rst while FULL and stalled, for 1 cycle.
//     -> wr_en=0 and all outputs 0 immediately (asynchronous).
//     -> Pointer=0, so req0 wins first after reset even if req3 is also valid.
//  5. req1 valid with addr=0, data=0x1234.
//     -> FILTER_EN defined: ready[1]=1, no wr_en pulse, pointer=2.
//     -> FILTER_EN undefined: wr_en=1, wr_addr=0, wr_data=0x1234.
//  6. req3 and req0 valid with pointer=3.
//     -> req3 is granted first, then req0 (wrap-around).
//     -> busy=1 throughout, and busy=0 the cycle after the last write drains.

Source files
------------

// File: rtl/riscv_rf_wr_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NREQ
// writeback requesters, with a one-entry registered output stage.
//
// Ports:
//   i_rfarb_clk / i_rfarb_rst   clock, async active-high reset
//   i_rfarb_req_valid/addr/data packed per-requester write requests
//   o_rfarb_req_ready           one-hot (or zero) accept
//   i_rfarb_wr_stall            downstream cannot take a write
//   o_rfarb_wr_en/addr/data     register-file write port
//   o_rfarb_grant_id            owner of the held write
//   o_rfarb_busy                request pending or stage occupied
//
// Option macro RISCV_RF_ARB_X0_FILTER_EN: accepted x0 writes are
// dropped instead of being loaded into the output stage.

module riscv_rf_wr_arbiter #(
  parameter  int XLEN = 32,
  parameter  int NREQ = 4,
  parameter  int AW   = 5,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 i_rfarb_clk,
  input  logic                 i_rfarb_rst,
  input  logic [NREQ-1:0]      i_rfarb_req_valid,
  output logic [NREQ-1:0]      o_rfarb_req_ready,
  input  logic [NREQ*AW-1:0]   i_rfarb_req_addr,
  input  logic [NREQ*XLEN-1:0] i_rfarb_req_data,
  input  logic                 i_rfarb_wr_stall,
  output logic                 o_rfarb_wr_en,
  output logic [AW-1:0]        o_rfarb_wr_addr,
  output logic [XLEN-1:0]      o_rfarb_wr_data,
  output logic [IW-1:0]        o_rfarb_grant_id,
  output logic                 o_rfarb_busy
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   ptr_nxt;
  logic [IW-1:0]   win;
  logic            found;
  logic            can_load;
  logic            xfer;
  logic            load;
  logic [AW-1:0]   sel_addr;
  logic [XLEN-1:0] sel_data;
  logic [AW-1:0]   addr_q;
  logic [XLEN-1:0] data_q;
  logic [IW-1:0]   id_q;
  int              idx;

  // First valid requester at or after the pointer, wrapping.
  always_comb begin
    found = 1'b0;
    win   = ptr;
    idx   = 0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && i_rfarb_req_valid[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

  assign sel_addr = i_rfarb_req_addr[int'(win)*AW +: AW];
  assign sel_data = i_rfarb_req_data[int'(win)*XLEN +: XLEN];

  assign can_load = !i_rfarb_rst &&
                    ((state == EMPTY) || !i_rfarb_wr_stall);
  assign xfer     = can_load && found;

`ifdef RISCV_RF_ARB_X0_FILTER_EN
  // x0 writes use up the slot but never reach the register file.
  assign load = xfer && (sel_addr != '0);
`else
  assign load = xfer;
`endif

  assign ptr_nxt = (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;

  always_comb begin
    o_rfarb_req_ready = '0;
    if (xfer) o_rfarb_req_ready = NREQ'(1) << win;
  end

  always_comb begin
    state_nxt = state;
    if (load)
      state_nxt = FULL;
    else if (state == FULL && !i_rfarb_wr_stall)
      state_nxt = EMPTY;
  end

  always_ff @(posedge i_rfarb_clk or posedge i_rfarb_rst) begin
    if (i_rfarb_rst) begin
      state  <= EMPTY;
      ptr    <= '0;
      addr_q <= '0;
      data_q <= '0;
      id_q   <= '0;
    end else begin
      state <= state_nxt;
      if (xfer) ptr <= ptr_nxt;
      if (load) begin
        addr_q <= sel_addr;
        data_q <= sel_data;
        id_q   <= win;
      end
    end
  end

  assign o_rfarb_wr_en    = (state == FULL);
  assign o_rfarb_wr_addr  = addr_q;
  assign o_rfarb_wr_data  = data_q;
  assign o_rfarb_grant_id = id_q;
  assign o_rfarb_busy     = (|i_rfarb_req_valid) | o_rfarb_wr_en;

endmodule

// File: tb/tb_riscv_rf_wr_arbiter.sv
// Self-checking bench for riscv_rf_wr_arbiter: directed table,
// hand-written corner sequences and a randomized model comparison.

module tb_riscv_rf_wr_arbiter;

  localparam int XLEN = 32;
  localparam int NREQ = 4;
  localparam int AW   = 5;
  localparam int IW   = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      valid;
  logic [NREQ-1:0]      ready;
  logic [NREQ*AW-1:0]   addr_bus;
  logic [NREQ*XLEN-1:0] data_bus;
  logic                 stall;
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic [XLEN-1:0]      wr_data;
  logic [IW-1:0]        grant_id;
  logic                 busy;

  int errors = 0;
  int checks = 0;

  riscv_rf_wr_arbiter #(.XLEN(XLEN), .NREQ(NREQ), .AW(AW)) dut (
    .i_rfarb_clk       (clk),
    .i_rfarb_rst       (rst),
    .i_rfarb_req_valid (valid),
    .o_rfarb_req_ready (ready),
    .i_rfarb_req_addr  (addr_bus),
    .i_rfarb_req_data  (data_bus),
    .i_rfarb_wr_stall  (stall),
    .o_rfarb_wr_en     (wr_en),
    .o_rfarb_wr_addr   (wr_addr),
    .o_rfarb_wr_data   (wr_data),
    .o_rfarb_grant_id  (grant_id),
    .o_rfarb_busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  // Inputs change at posedge+1; combinational checks at posedge+3.
  task automatic settle();
    #2;
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    valid = '0;
    stall = 1'b0;
    edge1();
    edge1();
    rst = 1'b0;
  endtask

  task automatic set_req(input int k, input logic [AW-1:0] a,
                         input logic [XLEN-1:0] d);
    addr_bus[k*AW +: AW]     = a;
    data_bus[k*XLEN +: XLEN] = d;
  endtask

  typedef struct {
    logic [3:0] v;
    logic       s;
    logic [3:0] rdy;
    logic       bsy;
    logic       en;
    int         id;
  } vec_t;

  vec_t tbl[15];

  // Reference model state
  bit          m_full;
  int          m_ptr;
  int          m_id;
  logic [AW-1:0]   m_addr;
  logic [XLEN-1:0] m_data;

  initial begin
    logic [NREQ-1:0] prev_v;
    logic [NREQ-1:0] prev_r;
    logic [NREQ-1:0] exp_r;
    int              w;
    bit              xf;
    bit              x0;

    rst = 1'b1;
    valid = '0;
    stall = 1'b0;
    addr_bus = '0;
    data_bus = '0;

    // Reset state, with a request already pending
    #3;
    valid = 4'hF;
    set_req(0, 5'd3, 32'h1);
    #1;
    chk("rst_wr_en", {31'b0, wr_en}, 0);
    chk("rst_addr", {27'b0, wr_addr}, 0);
    chk("rst_data", wr_data, 0);
    chk("rst_id", {30'b0, grant_id}, 0);
    chk("rst_ready", {28'b0, ready}, 0);
    do_reset();

    // Single write: accept, 1-cycle latency, then drain
    set_req(0, 5'd5, 32'hDEADBEEF);
    valid = 4'h1;
    settle();
    chk("t1_ready", {28'b0, ready}, 1);
    edge1();
    valid = '0;
    chk("t1_en", {31'b0, wr_en}, 1);
    chk("t1_addr", {27'b0, wr_addr}, 5);
    chk("t1_data", wr_data, 32'hDEADBEEF);
    chk("t1_id", {30'b0, grant_id}, 0);
    edge1();
    chk("t1_drain", {31'b0, wr_en}, 0);

    // Directed table: fairness, stall hold, drain+refill, wrap
    tbl[0]  = '{4'hF, 1'b0, 4'h1, 1'b1, 1'b1, 0};
    tbl[1]  = '{4'hF, 1'b0, 4'h2, 1'b1, 1'b1, 1};
    tbl[2]  = '{4'hF, 1'b0, 4'h4, 1'b1, 1'b1, 2};
    tbl[3]  = '{4'hF, 1'b0, 4'h8, 1'b1, 1'b1, 3};
    tbl[4]  = '{4'hF, 1'b0, 4'h1, 1'b1, 1'b1, 0};
    tbl[5]  = '{4'h2, 1'b0, 4'h2, 1'b1, 1'b1, 1};
    tbl[6]  = '{4'h4, 1'b1, 4'h0, 1'b1, 1'b1, 1};
    tbl[7]  = '{4'h4, 1'b1, 4'h0, 1'b1, 1'b1, 1};
    tbl[8]  = '{4'h4, 1'b1, 4'h0, 1'b1, 1'b1, 1};
    tbl[9]  = '{4'h4, 1'b0, 4'h4, 1'b1, 1'b1, 2};
    tbl[10] = '{4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 2};
    tbl[11] = '{4'h9, 1'b0, 4'h8, 1'b1, 1'b1, 3};
    tbl[12] = '{4'h1, 1'b0, 4'h1, 1'b1, 1'b1, 0};
    tbl[13] = '{4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 0};
    tbl[14] = '{4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 0};

    do_reset();
    for (int k = 0; k < NREQ; k++)
      set_req(k, AW'(6 + k), 32'hC0DE0000 | k);
    for (int r = 0; r < 15; r++) begin
      valid = tbl[r].v;
      stall = tbl[r].s;
      settle();
      chk($sformatf("tbl%0d_ready", r), {28'b0, ready}, {28'b0, tbl[r].rdy});
      chk($sformatf("tbl%0d_busy", r), {31'b0, busy}, {31'b0, tbl[r].bsy});
      edge1();
      chk($sformatf("tbl%0d_en", r), {31'b0, wr_en}, {31'b0, tbl[r].en});
      chk($sformatf("tbl%0d_id", r), {30'b0, grant_id}, tbl[r].id);
      chk($sformatf("tbl%0d_addr", r), {27'b0, wr_addr}, 6 + tbl[r].id);
      chk($sformatf("tbl%0d_data", r), wr_data, 32'hC0DE0000 | tbl[r].id);
    end

    // Async reset while full and stalled; pointer returns to 0
    valid = 4'h2;
    stall = 1'b0;
    edge1();
    valid = 4'h9;
    stall = 1'b1;
    #1;
    chk("t4_pre_en", {31'b0, wr_en}, 1);
    rst = 1'b1;
    #1;
    chk("t4_en", {31'b0, wr_en}, 0);
    chk("t4_addr", {27'b0, wr_addr}, 0);
    chk("t4_data", wr_data, 0);
    chk("t4_id", {30'b0, grant_id}, 0);
    chk("t4_ready", {28'b0, ready}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    stall = 1'b0;
    settle();
    chk("t4_ready_after", {28'b0, ready}, 1);
    edge1();
    chk("t4_id_after", {30'b0, grant_id}, 0);
    chk("t4_en_after", {31'b0, wr_en}, 1);

    // x0 write handling
    do_reset();
    set_req(1, 5'd0, 32'h1234);
    valid = 4'h2;
    settle();
    chk("t5_ready", {28'b0, ready}, 2);
    edge1();
    valid = 4'hF;
    set_req(1, 5'd7, 32'h0);
`ifdef RISCV_RF_ARB_X0_FILTER_EN
    chk("t5_en", {31'b0, wr_en}, 0);
`else
    chk("t5_en", {31'b0, wr_en}, 1);
    chk("t5_addr", {27'b0, wr_addr}, 0);
    chk("t5_data", wr_data, 32'h1234);
`endif
    settle();
    chk("t5_ptr", {28'b0, ready}, 4);
    edge1();

    // Randomized run against the reference model
    do_reset();
    m_full = 0;
    m_ptr = 0;
    m_id = 0;
    m_addr = '0;
    m_data = '0;
    prev_v = '0;
    prev_r = '0;
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!(prev_v[k] && !prev_r[k])) begin
          valid[k] = ($urandom_range(0, 2) != 0);
          set_req(k, AW'($urandom_range(0, 31)), $urandom);
        end
      end
      stall = ($urandom_range(0, 2) == 0);
      w = -1;
      for (int j = 0; j < NREQ; j++)
        if (w < 0 && valid[(m_ptr + j) % NREQ]) w = (m_ptr + j) % NREQ;
      xf = (w >= 0) && (!m_full || !stall);
      exp_r = xf ? NREQ'(1) << w : '0;
      settle();
      chk("rnd_ready", {28'b0, ready}, {28'b0, exp_r});
      chk("rnd_busy", {31'b0, busy}, {31'b0, (valid != 0) || m_full});
      prev_v = valid;
      prev_r = ready;
      x0 = 0;
`ifdef RISCV_RF_ARB_X0_FILTER_EN
      if (xf) x0 = (addr_bus[w*AW +: AW] == 0);
`endif
      if (xf && !x0) begin
        m_full = 1;
        m_id = w;
        m_addr = addr_bus[w*AW +: AW];
        m_data = data_bus[w*XLEN +: XLEN];
      end else if (m_full && !stall) begin
        m_full = 0;
      end
      if (xf) m_ptr = (w + 1) % NREQ;
      edge1();
      chk("rnd_en", {31'b0, wr_en}, {31'b0, m_full});
      chk("rnd_id", {30'b0, grant_id}, m_id);
      chk("rnd_addr", {27'b0, wr_addr}, {27'b0, m_addr});
      chk("rnd_data", wr_data, m_data);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
